// File: rtl/mbr_mem_responder.sv
// Memory-side responder: four-phase req/ack, programmable wait states,
// DEPTH x 10-bit word store with out-of-range flagging.
module mbr_mem_responder #(
  parameter int DEPTH       = 48,
  parameter int AW          = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [9:0]    wdata,
  output logic          ack,
  output logic [9:0]    rdata,
  output logic          err,
  output logic          busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2^AW still compares correctly.
  localparam logic [AW:0] DEPTH_W  = DEPTH[AW:0];
  localparam logic [3:0]  WAIT_CNT = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [9:0]    wdata_q, wdata_d;
  logic          ack_q, ack_d;
  logic [9:0]    rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [9:0]    mem [DEPTH];
  logic          in_range;
  logic [IW-1:0] idx;
  logic          access;
  logic          mem_we;

  assign in_range = ({1'b0, addr_q} < DEPTH_W);
  assign idx      = addr_q[IW-1:0];
  assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we   = access && we_q && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_WAIT;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WAIT_CNT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          err_d   = !in_range;
          if (!we_q) rdata_d = in_range ? mem[idx] : 10'd0;
        end
      end
      S_ACK: begin
        if (!req) begin
          state_d = S_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 10'd0;
      ack_q   <= 1'b0;
      rdata_q <= 10'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is never cleared; reset only blocks a write still pending in WAIT.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[idx] <= wdata_q;
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mbr_mem_responder.sv
// Directed bench for mbr_mem_responder: default instance (WAIT_CYCLES=2)
// plus a zero-wait instance for the latency corner.
module tb_mbr_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       req, we;
  logic [5:0] addr;
  logic [9:0] wdata;
  logic       ack, err, busy;
  logic [9:0] rdata;

  logic       req1, we1;
  logic [5:0] addr1;
  logic [9:0] wdata1;
  logic       ack1, err1, busy1;
  logic [9:0] rdata1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mbr_mem_responder #(.DEPTH(48), .AW(6), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy)
  );

  mbr_mem_responder #(.DEPTH(48), .AW(6), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Full handshake on the default instance; starts and ends on a negedge with req low.
  task automatic txn(input logic w, input logic [5:0] a, input logic [9:0] d, input int hold,
                     output int lat, output logic busy_w, output logic ack_hold,
                     output logic ack_drop, output logic busy_end);
    req = 1'b1; we = w; addr = a; wdata = d;
    lat = -1; busy_w = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) busy_w = busy;
      if (ack) begin lat = i; break; end
    end
    repeat (hold) @(negedge clk);
    ack_hold = ack;
    req = 1'b0;
    @(negedge clk);
    ack_drop = ack;
    busy_end = busy;
  endtask

  int   lat, n;
  logic bw, ah, ad, be;

  initial begin
    reset = 1'b0; req = 1'b1; we = 1'b1; addr = 6'd1; wdata = 10'h3FF;
    req1 = 1'b0; we1 = 1'b0; addr1 = 6'd0; wdata1 = 10'd0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
    end
    req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    txn(1'b1, 6'd5, 10'h2A5, 0, lat, bw, ah, ad, be);
    chk("wr5_lat", lat, 3);
    chk("wr5_busy_wait", bw, 1);
    chk("wr5_err", err, 0);
    chk("wr5_ack_drop", ad, 0);

    txn(1'b0, 6'd5, 10'h000, 2, lat, bw, ah, ad, be);
    chk("rd5_lat", lat, 3);
    chk("rd5_rdata", rdata, 10'h2A5);
    chk("rd5_err", err, 0);
    chk("rd5_ack_hold", ah, 1);
    chk("rd5_ack_drop", ad, 0);
    chk("rd5_busy_end", be, 0);

    txn(1'b1, 6'd15, 10'h0AA, 0, lat, bw, ah, ad, be);
    txn(1'b1, 6'd47, 10'h011, 0, lat, bw, ah, ad, be);
    chk("wr47_err", err, 0);
    txn(1'b0, 6'd50, 10'h000, 0, lat, bw, ah, ad, be);
    chk("rd50_err", err, 1);
    chk("rd50_rdata", rdata, 0);
    txn(1'b0, 6'd5, 10'h000, 0, lat, bw, ah, ad, be);
    chk("rd5b_err_clear", err, 0);
    txn(1'b1, 6'd63, 10'h3FF, 0, lat, bw, ah, ad, be);
    chk("wr63_err", err, 1);
    chk("wr63_rdata_held", rdata, 10'h2A5);
    txn(1'b0, 6'd47, 10'h000, 0, lat, bw, ah, ad, be);
    chk("rd47_rdata", rdata, 10'h011);
    chk("rd47_err", err, 0);
    txn(1'b0, 6'd15, 10'h000, 0, lat, bw, ah, ad, be);
    chk("rd15_no_alias", rdata, 10'h0AA);

    // Inputs change while in WAIT; only the captured values count.
    txn(1'b1, 6'd7, 10'h222, 0, lat, bw, ah, ad, be);
    req = 1'b1; we = 1'b1; addr = 6'd3; wdata = 10'h111;
    @(negedge clk);
    addr = 6'd7; wdata = 10'h3C3; we = 1'b0;
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack) begin n = i; break; end
    end
    chk("stab_lat", n, 2);
    req = 1'b0;
    @(negedge clk);
    txn(1'b0, 6'd3, 10'h000, 0, lat, bw, ah, ad, be);
    chk("stab_rd3", rdata, 10'h111);
    txn(1'b0, 6'd7, 10'h000, 0, lat, bw, ah, ad, be);
    chk("stab_rd7", rdata, 10'h222);

    // req drops one edge after capture.
    req = 1'b1; we = 1'b1; addr = 6'd20; wdata = 10'h155;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack) n++;
    end
    chk("early_ack_cycles", n, 1);
    chk("early_busy_end", busy, 0);
    txn(1'b0, 6'd20, 10'h000, 0, lat, bw, ah, ad, be);
    chk("early_rd20", rdata, 10'h155);

    // Reset during WAIT drops the pending write.
    txn(1'b1, 6'd9, 10'h0F0, 0, lat, bw, ah, ad, be);
    req = 1'b1; we = 1'b1; addr = 6'd9; wdata = 10'h155;
    @(negedge clk);
    chk("rstw_busy_before", busy, 1);
    reset = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("rstw_busy", busy, 0);
    chk("rstw_ack", ack, 0);
    chk("rstw_rdata", rdata, 0);
    reset = 1'b1;
    @(negedge clk);
    txn(1'b0, 6'd9, 10'h000, 0, lat, bw, ah, ad, be);
    chk("rstw_rd9", rdata, 10'h0F0);

    // Reset during ACK keeps the completed write.
    req = 1'b1; we = 1'b1; addr = 6'd9; wdata = 10'h133;
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack) begin n = i; break; end
    end
    chk("rsta_lat", n, 3);
    reset = 1'b0;
    @(negedge clk);
    chk("rsta_ack", ack, 0);
    reset = 1'b1; req = 1'b0;
    @(negedge clk);
    txn(1'b0, 6'd9, 10'h000, 0, lat, bw, ah, ad, be);
    chk("rsta_rd9", rdata, 10'h133);

    // Zero wait states: ack one edge after capture.
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd2; wdata1 = 10'h1AB;
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack1) begin n = i; break; end
    end
    chk("wc0_wr_lat", n, 1);
    req1 = 1'b0;
    @(negedge clk);
    chk("wc0_ack_drop", ack1, 0);
    req1 = 1'b1; we1 = 1'b0;
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack1) begin n = i; break; end
    end
    chk("wc0_rd_lat", n, 1);
    chk("wc0_rdata", rdata1, 10'h1AB);
    chk("wc0_err", err1, 0);
    req1 = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
